// File: rtl/pe_sched_pkg.sv
// Shared state encoding and counter-width helpers for the input-channel-parallel PE
// scheduler and its raster position counter.
package pe_sched_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StIssue   = 3'd1,
      StWaitAck = 3'd2,
      StDrain   = 3'd3,
      StDone    = 3'd4
   } sched_state_e;

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefDataWidth   = 72;
   localparam int unsigned DefColWidth    = cnt_width(5);
   localparam int unsigned DefRowWidth    = cnt_width(5);
   localparam int unsigned DefInflightW   = cnt_width(2 + 1);

endpackage

// File: rtl/pe_incha_scheduler_if.sv
// Window-stream (s_*) and PE handshake (pe_*) bundle for pe_incha_scheduler.
// The scheduler takes the slave side; the window source and PE model take the master side.
interface pe_incha_scheduler_if #(
   parameter int unsigned DATA_WIDTH = 72
) ();

   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [DATA_WIDTH-1:0] pe_data;
   logic                  pe_valid;
   logic                  pe_ready;
   logic                  pe_ack;
   logic                  pe_o_valid;

   modport slave (
      input  s_data, s_valid, pe_ready, pe_ack, pe_o_valid,
      output s_ready, pe_data, pe_valid
   );

   modport master (
      output s_data, s_valid, pe_ready, pe_ack, pe_o_valid,
      input  s_ready, pe_data, pe_valid
   );

endinterface

// File: rtl/raster_pos_counter.sv
// Column/row position of the next output window, advanced in raster order.
// last flags the final window of the OUT_WIDTH x OUT_HEIGHT map.
module raster_pos_counter
   import pe_sched_pkg::*;
#(
   parameter int unsigned OUT_WIDTH  = 5,
   parameter int unsigned OUT_HEIGHT = 5,
   parameter int unsigned ColW       = cnt_width(OUT_WIDTH),
   parameter int unsigned RowW       = cnt_width(OUT_HEIGHT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            advance,
   output logic [ColW-1:0] col,
   output logic [RowW-1:0] row,
   output logic            last
);

   localparam logic [ColW-1:0] ColLast = ColW'(OUT_WIDTH - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(OUT_HEIGHT - 1);

   logic [ColW-1:0] col_q, col_d;
   logic [RowW-1:0] row_q, row_d;
   logic            col_last, row_last;

   assign col_last = (col_q == ColLast);
   assign row_last = (row_q == RowLast);
   assign last     = col_last && row_last;
   assign col      = col_q;
   assign row      = row_q;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else if (advance) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/pe_incha_scheduler.sv
// Issues one frame of convolution windows to a single PE and tracks outstanding results.
// Define PE_INCHA_SCHED_PERF_EN to add the stall_cnt / frame_cycles performance counters.
module pe_incha_scheduler
   import pe_sched_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 72,
   parameter int unsigned OUT_WIDTH    = 5,
   parameter int unsigned OUT_HEIGHT   = 5,
   parameter int unsigned MAX_INFLIGHT = 2,
   parameter int unsigned ColW         = cnt_width(OUT_WIDTH),
   parameter int unsigned RowW         = cnt_width(OUT_HEIGHT)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       err_ovf,
   output logic [ColW-1:0]            col,
   output logic [RowW-1:0]            row,
   pe_incha_scheduler_if.slave        bus
`ifdef PE_INCHA_SCHED_PERF_EN
   ,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                frame_cycles
`endif
);

   localparam int unsigned     IfW   = cnt_width(MAX_INFLIGHT + 1);
   localparam logic [IfW-1:0]  MaxIf = IfW'(MAX_INFLIGHT);

   sched_state_e          state_q, state_d;
   logic [IfW-1:0]        inflight_q, inflight_d;
   logic                  pe_valid_q, pe_valid_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] pe_data_q;
   logic                  start_take, xfer, ack_take, res_ok, pos_last, pos_clear;

   assign start_take = (state_q == StIdle) && start && !abort;
   // Gated by abort so no window is swallowed in the cycle the frame is torn down.
   assign bus.s_ready = (state_q == StIssue) && bus.pe_ready && (inflight_q < MaxIf) && !abort;
   assign xfer        = bus.s_valid && bus.s_ready;
   assign ack_take    = (state_q == StWaitAck) && bus.pe_ack && !abort;
   assign res_ok      = bus.pe_o_valid && (inflight_q != '0);
   assign pos_clear   = start_take || abort;

   assign busy         = (state_q != StIdle);
   assign frame_done   = (state_q == StDone);
   assign err_ovf      = err_q;
   assign bus.pe_valid = pe_valid_q;
   assign bus.pe_data  = pe_data_q;

   raster_pos_counter #(
      .OUT_WIDTH  (OUT_WIDTH),
      .OUT_HEIGHT (OUT_HEIGHT),
      .ColW       (ColW),
      .RowW       (RowW)
   ) u_pos (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (pos_clear),
      .advance (ack_take),
      .col     (col),
      .row     (row),
      .last    (pos_last)
   );

   always_comb begin
      state_d    = state_q;
      pe_valid_d = pe_valid_q;
      case (state_q)
         StIdle:    if (start) state_d = StIssue;
         StIssue: begin
            if (xfer) begin
               state_d    = StWaitAck;
               pe_valid_d = 1'b1;
            end
         end
         StWaitAck: begin
            if (bus.pe_ack) begin
               pe_valid_d = 1'b0;
               state_d    = pos_last ? StDrain : StIssue;
            end
         end
         StDrain:   if (inflight_q == '0) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
      if (abort) begin
         state_d    = StIdle;
         pe_valid_d = 1'b0;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      err_d      = err_q;
      if (abort || start_take) begin
         inflight_d = '0;
      end else begin
         case ({ack_take, res_ok})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
         endcase
      end
      if (start_take) begin
         err_d = 1'b0;
      end else if (bus.pe_o_valid && (inflight_q == '0)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         inflight_q <= '0;
         pe_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         pe_valid_q <= pe_valid_d;
         err_q      <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) pe_data_q <= bus.s_data;
   end

`ifdef PE_INCHA_SCHED_PERF_EN
   logic [31:0] stall_q, cyc_q;

   assign stall_cnt    = stall_q;
   assign frame_cycles = cyc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         cyc_q   <= '0;
      end else if (start_take) begin
         stall_q <= '0;
         cyc_q   <= '0;
      end else begin
         if ((state_q == StIssue) && bus.s_valid && !bus.s_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
         end
         if ((state_q inside {StIssue, StWaitAck, StDrain}) && (cyc_q != '1)) begin
            cyc_q <= cyc_q + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pe_incha_scheduler.sv
// Scoreboard bench for pe_incha_scheduler on a 4x3 output map with MAX_INFLIGHT=2:
// a window source pushes expectations, a PE model acks and returns results, a monitor checks.
module tb_pe_incha_scheduler;

   localparam int DW   = 72;
   localparam int W    = 4;
   localparam int H    = 3;
   localparam int MI   = 2;
   localparam int NWIN = W * H;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy, frame_done, err_ovf;
   logic [1:0] col, row;
`ifdef PE_INCHA_SCHED_PERF_EN
   logic [31:0] stall_cnt, frame_cycles;
`endif

   pe_incha_scheduler_if #(.DATA_WIDTH(DW)) bus ();

   pe_incha_scheduler #(
      .DATA_WIDTH   (DW),
      .OUT_WIDTH    (W),
      .OUT_HEIGHT   (H),
      .MAX_INFLIGHT (MI)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_ovf      (err_ovf),
      .col          (col),
      .row          (row),
      .bus          (bus)
`ifdef PE_INCHA_SCHED_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .frame_cycles (frame_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
      int            r;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass = 0;
   int         done_cnt = 0;
   logic [7:0] frame_tag = 8'hA1;
   logic       src_en = 1'b1;
   int         res_delay = 3;
   int         ack_limit = 1000;
   int         inject_cnt = 0;

   function automatic logic [DW-1:0] mk(input int k, input logic [7:0] tag);
      return {tag, 32'hC0DE0000 | 32'(k), 32'(k * 7 + 1)};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Window source: expected window recorded at the cycle the transfer happens.
   initial begin : src
      int   k;
      logic x, rs;
      exp_t e;
      k = 0;
      bus.s_valid = 1'b0;
      bus.s_data  = mk(0, frame_tag);
      forever begin
         @(negedge clk);
         x  = bus.s_valid && bus.s_ready;
         rs = (start && !busy) || abort;
         if (x) begin
            e.d = mk(k, frame_tag);
            e.c = k % W;
            e.r = k / W;
            exp_q.push_back(e);
         end
         @(posedge clk);
         #1;
         if (rs) k = 0;
         else if (x) k++;
         bus.s_data  = mk(k, frame_tag);
         bus.s_valid = src_en;
      end
   end

   // PE model: acks a presented window at once, returns its result res_delay cycles later.
   initial begin : pe
      int   q[$];
      int   acks, inj_seen;
      logic fire;
      acks = 0;
      inj_seen = 0;
      bus.pe_ack = 1'b0;
      bus.pe_o_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         fire = 1'b0;
         foreach (q[i]) q[i]--;
         if (q.size() > 0 && q[0] <= 0) begin
            void'(q.pop_front());
            fire = 1'b1;
         end
         if (inject_cnt != inj_seen) begin
            inj_seen++;
            fire = 1'b1;
         end
         if (!busy) acks = 0;
         if (bus.pe_valid && acks < ack_limit) begin
            acks++;
            q.push_back(res_delay);
            bus.pe_ack = 1'b1;
         end else begin
            bus.pe_ack = 1'b0;
         end
         bus.pe_o_valid = fire;
      end
   end

   // Monitor: scoreboard pop on each new pe_valid, outstanding-window model.
   initial begin : mon
      logic pv_prev;
      int   out_cnt, win, nxt;
      exp_t e;
      pv_prev = 1'b0;
      out_cnt = 0;
      win = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (start && !busy) win = 0;
            if (bus.pe_valid && !pv_prev) begin
               win++;
               check("sb_pending", int'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_d("pe_data", bus.pe_data, e.d);
                  check("col", int'(col), e.c);
                  check("row", int'(row), e.r);
               end
            end
            pv_prev = bus.pe_valid;
            if (busy && out_cnt >= MI) check("s_ready_at_limit", int'(bus.s_ready), 0);
            if (frame_done) begin
               done_cnt++;
               check("windows_per_frame", win, NWIN);
            end
            if (abort) begin
               out_cnt = 0;
            end else begin
               nxt = out_cnt;
               if (bus.pe_ack && bus.pe_valid) nxt++;
               if (bus.pe_o_valid && out_cnt > 0) nxt--;
               if (bus.pe_ack && bus.pe_valid) check("inflight_bound", int'(nxt <= MI), 1);
               out_cnt = nxt;
            end
         end
      end
   end

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc, input int exp_frames);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      check("frame_done_seen", int'(seen), 1);
      @(posedge clk);
      #1;
      check("busy_after_done", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check("frame_done_once", done_cnt, exp_frames);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin : main
      logic found;
      bus.pe_ready = 1'b1;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_err_ovf", int'(err_ovf), 0);
      check("rst_s_ready", int'(bus.s_ready), 0);
      check("rst_pe_valid", int'(bus.pe_valid), 0);
      check("rst_col", int'(col), 0);
      check("rst_row", int'(row), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Frame A: immediate acks, results 3 cycles after each ack.
      do_start();
      wait_done(400, 1);

      // Frame B: PE not ready for 20 cycles, then slow results so the inflight limit binds.
      frame_tag = 8'hB2;
      res_delay = 10;
      bus.pe_ready = 1'b0;
      do_start();
      for (int i = 0; i < 20; i++) begin
         check("stall_s_ready", int'(bus.s_ready), 0);
         @(posedge clk);
         #1;
      end
      check("stall_pe_valid", int'(bus.pe_valid), 0);
      check_d("stall_pe_data", bus.pe_data, mk(NWIN - 1, 8'hA1));
      check("stall_busy", int'(busy), 1);
`ifdef PE_INCHA_SCHED_PERF_EN
      check("stall_cnt", int'(stall_cnt), 20);
`endif
      bus.pe_ready = 1'b1;
      wait_done(800, 2);

      // Frame C: each result coincides with the next ack.
      frame_tag = 8'hC3;
      res_delay = 2;
      do_start();
      wait_done(400, 3);
      check("err_after_overlap", int'(err_ovf), 0);

      // Frame D: window 7 is never acked; abort while it waits.
      frame_tag = 8'hD4;
      res_delay = 6;
      ack_limit = 7;
      do_start();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         if (bus.pe_valid && col == 2'd3 && row == 2'd1) found = 1'b1;
      end
      check("reached_window7", int'(found), 1);
      @(posedge clk);
      #1;
      check("window7_held", int'(bus.pe_valid), 1);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_pe_valid", int'(bus.pe_valid), 0);
      check("abort_s_ready", int'(bus.s_ready), 0);
      check("abort_col", int'(col), 0);
      check("abort_row", int'(row), 0);
      repeat (10) @(posedge clk);
      #1;
      check("late_result_err", int'(err_ovf), 1);
      check("abort_sb_empty", exp_q.size(), 0);

      // Frame E: clean frame after the abort; start clears err_ovf.
      frame_tag = 8'hE5;
      res_delay = 3;
      ack_limit = 1000;
      do_start();
      check("start_clears_err", int'(err_ovf), 0);
      wait_done(400, 4);

      // Spurious result with nothing outstanding.
      inject_cnt++;
      repeat (3) @(posedge clk);
      #1;
      check("spurious_err", int'(err_ovf), 1);
      repeat (5) @(posedge clk);
      #1;
      check("spurious_err_sticky", int'(err_ovf), 1);

      frame_tag = 8'hF6;
      res_delay = 4;
      do_start();
      check("start_clears_err2", int'(err_ovf), 0);
      wait_done(400, 5);
      check("final_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
